// File: rtl/dfi_pkg.sv
// Shared types for the half-rate DFI initiator: FSM states, DFI command tuples, default widths.
package dfi_pkg;

  localparam int DEF_NUM_AD = 13;
  localparam int DEF_NUM_BA = 2;
  localparam int DEF_NUM_D  = 64;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_NOP = 4'b0111;
  localparam cmd_t CMD_ACT = 4'b0011;
  localparam cmd_t CMD_RD  = 4'b0101;
  localparam cmd_t CMD_WR  = 4'b0100;
  localparam cmd_t CMD_PRE = 4'b0010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACT,
    ST_WAIT_RCD,
    ST_CMD,
    ST_DATA,
    ST_WAIT_WR,
    ST_WAIT_RD,
    ST_PRE,
    ST_WAIT_RP
  } state_t;

  // Per-phase byte-mask width for a given per-phase data width.
  function automatic int mask_w(input int num_d);
    return num_d / 8;
  endfunction

endpackage

// File: rtl/dfi_initiator_if.sv
// Request/response port plus both DFI phases of the initiator.
// master = initiator side; slave = request source and PHY side.
interface dfi_initiator_if
  import dfi_pkg::*;
#(
  parameter int NUM_AD = DEF_NUM_AD,
  parameter int NUM_BA = DEF_NUM_BA,
  parameter int NUM_D  = DEF_NUM_D
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_BA-1:0]     req_bank;
  logic [NUM_AD-1:0]     req_row;
  logic [NUM_AD-1:0]     req_col;
  logic [2*NUM_D-1:0]    req_wdata;
  logic [NUM_D/4-1:0]    req_wmask;
  logic                  rsp_valid;
  logic [2*NUM_D-1:0]    rsp_rdata;
  logic                  rsp_err;

  logic                  dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0;
  logic                  dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1;
  logic [NUM_AD-1:0]     dfi_address_p0, dfi_address_p1;
  logic [NUM_BA-1:0]     dfi_bank_p0, dfi_bank_p1;
  logic                  dfi_wrdata_en_p1;
  logic [NUM_D-1:0]      dfi_wrdata_p0, dfi_wrdata_p1;
  logic [NUM_D/8-1:0]    dfi_wrdata_mask_p0, dfi_wrdata_mask_p1;
  logic                  dfi_rddata_en_p0;
  logic [NUM_D-1:0]      dfi_rddata_w0, dfi_rddata_w1;
  logic                  dfi_rddata_valid_w0, dfi_rddata_valid_w1;

  modport master (
    input  req_valid, req_we, req_bank, req_row, req_col, req_wdata, req_wmask,
    input  dfi_rddata_w0, dfi_rddata_w1, dfi_rddata_valid_w0, dfi_rddata_valid_w1,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0,
    output dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1,
    output dfi_address_p0, dfi_address_p1, dfi_bank_p0, dfi_bank_p1,
    output dfi_wrdata_en_p1, dfi_wrdata_p0, dfi_wrdata_p1,
    output dfi_wrdata_mask_p0, dfi_wrdata_mask_p1, dfi_rddata_en_p0
  );

  modport slave (
    output req_valid, req_we, req_bank, req_row, req_col, req_wdata, req_wmask,
    output dfi_rddata_w0, dfi_rddata_w1, dfi_rddata_valid_w0, dfi_rddata_valid_w1,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0,
    input  dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1,
    input  dfi_address_p0, dfi_address_p1, dfi_bank_p0, dfi_bank_p1,
    input  dfi_wrdata_en_p1, dfi_wrdata_p0, dfi_wrdata_p1,
    input  dfi_wrdata_mask_p0, dfi_wrdata_mask_p1, dfi_rddata_en_p0
  );

endinterface

// File: rtl/dfi_phase_drv.sv
// One DFI phase: registers command tuple, address and bank for one cycle; NOP with zero address otherwise.
// Latency 1 cycle from load; no backpressure.
module dfi_phase_drv
  import dfi_pkg::*;
#(
  parameter int NUM_AD = DEF_NUM_AD,
  parameter int NUM_BA = DEF_NUM_BA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  cmd_t              cmd,
  input  logic [NUM_AD-1:0] addr,
  input  logic [NUM_BA-1:0] bank,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [NUM_AD-1:0] address,
  output logic [NUM_BA-1:0] ba
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
      address                    <= '0;
      ba                         <= '0;
    end else if (load) begin
      {cs_n, ras_n, cas_n, we_n} <= cmd;
      address                    <= addr;
      ba                         <= bank;
    end else begin
      {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
      address                    <= '0;
      ba                         <= '0;
    end
  end

endmodule

// File: rtl/dfi_initiator.sv
// Half-rate DFI master: one request at a time, closed-page ACT -> WRITE/READ -> PRE-all; req_ready only in IDLE.
// All outputs registered; optional read timeout when DFI_RD_TIMEOUT_EN is defined.
module dfi_initiator
  import dfi_pkg::*;
#(
  parameter int NUM_AD     = DEF_NUM_AD,
  parameter int NUM_BA     = DEF_NUM_BA,
  parameter int NUM_D      = DEF_NUM_D,
  parameter int T_RCD      = 2,
  parameter int T_WR       = 3,
  parameter int T_RP       = 2,
  parameter int RD_TIMEOUT = 15
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  dfi_initiator_if.master bus
);

  localparam int MW = mask_w(NUM_D);

  // Wait states count down from T-2 so that they last T-1 cycles.
  localparam logic [3:0] RCD_LD  = 4'(T_RCD > 1 ? T_RCD - 2 : 0);
  localparam logic [3:0] WR_LD   = 4'(T_WR  > 1 ? T_WR  - 2 : 0);
  localparam logic [3:0] RP_LD   = 4'(T_RP  > 1 ? T_RP  - 2 : 0);
  localparam logic [3:0] RD_LAST = 4'(RD_TIMEOUT - 1);

  if (T_RCD < 1 || T_WR < 1 || T_RP < 1 || RD_TIMEOUT < 1 || RD_TIMEOUT > 15 || NUM_AD < 11)
  begin : g_bad_param
    $error("dfi_initiator: parameter out of range");
  end

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic                 we_q;
  logic [NUM_BA-1:0]    bank_q;
  logic [NUM_AD-1:0]    col_q;
  logic [2*NUM_D-1:0]   wdata_q;
  logic [2*MW-1:0]      wmask_q;
  logic                 accept, rd_hit, rd_to;

  logic                 p0_load, p1_load;
  cmd_t                 p0_cmd, p1_cmd;
  logic [NUM_AD-1:0]    p0_addr, p1_addr;
  logic [NUM_BA-1:0]    p0_bank, p1_bank;

  assign accept = bus.req_valid & bus.req_ready;
  assign rd_hit = bus.dfi_rddata_valid_w0 & bus.dfi_rddata_valid_w1;

`ifdef DFI_RD_TIMEOUT_EN
  assign rd_to = ~rd_hit & (cnt == RD_LAST);
`else
  assign rd_to = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (accept) state_nxt = ST_ACT;
      ST_ACT:      state_nxt = (T_RCD > 1) ? ST_WAIT_RCD : ST_CMD;
      ST_WAIT_RCD: if (cnt == 4'd0) state_nxt = ST_CMD;
      ST_CMD:      state_nxt = ST_DATA;
      ST_DATA:     state_nxt = !we_q ? ST_WAIT_RD : ((T_WR > 1) ? ST_WAIT_WR : ST_PRE);
      ST_WAIT_WR:  if (cnt == 4'd0) state_nxt = ST_PRE;
      ST_WAIT_RD:  if (rd_hit || rd_to) state_nxt = ST_PRE;
      ST_PRE:      state_nxt = (T_RP > 1) ? ST_WAIT_RP : ST_IDLE;
      ST_WAIT_RP:  if (cnt == 4'd0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Phase commands are decoded from the state being entered so they appear with it.
  always_comb begin
    p0_load = 1'b0;
    p0_cmd  = CMD_NOP;
    p0_addr = '0;
    p0_bank = '0;
    p1_load = 1'b0;
    p1_cmd  = CMD_NOP;
    p1_addr = '0;
    p1_bank = '0;
    unique case (state_nxt)
      ST_ACT: begin
        p0_load = 1'b1;
        p0_cmd  = CMD_ACT;
        p0_addr = bus.req_row;
        p0_bank = bus.req_bank;
      end
      ST_CMD: begin
        if (we_q) begin
          p1_load = 1'b1;
          p1_cmd  = CMD_WR;
          p1_addr = col_q;
          p1_bank = bank_q;
        end else begin
          p0_load = 1'b1;
          p0_cmd  = CMD_RD;
          p0_addr = col_q;
          p0_bank = bank_q;
        end
      end
      ST_PRE: begin
        p0_load     = 1'b1;
        p0_cmd      = CMD_PRE;
        p0_addr[10] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      we_q                   <= 1'b0;
      bank_q                 <= '0;
      col_q                  <= '0;
      wdata_q                <= '0;
      wmask_q                <= '0;
      bus.req_ready          <= 1'b1;
      bus.rsp_valid          <= 1'b0;
      bus.rsp_rdata          <= '0;
      bus.rsp_err            <= 1'b0;
      bus.dfi_wrdata_en_p1   <= 1'b0;
      bus.dfi_wrdata_p0      <= '0;
      bus.dfi_wrdata_p1      <= '0;
      bus.dfi_wrdata_mask_p0 <= '0;
      bus.dfi_wrdata_mask_p1 <= '0;
      bus.dfi_rddata_en_p0   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.req_ready <= (state_nxt == ST_IDLE);
      bus.rsp_valid <= (state_nxt == ST_PRE);
      bus.rsp_err   <= (state == ST_WAIT_RD) & rd_to;

      if (accept) begin
        we_q       <= bus.req_we;
        bank_q     <= bus.req_bank;
        col_q      <= bus.req_col;
        col_q[10]  <= 1'b0;
        wdata_q    <= bus.req_wdata;
        wmask_q    <= bus.req_wmask;
      end

      bus.dfi_rddata_en_p0 <= (state_nxt == ST_DATA) & ~we_q;
      if ((state_nxt == ST_DATA) && we_q) begin
        bus.dfi_wrdata_en_p1   <= 1'b1;
        bus.dfi_wrdata_p0      <= wdata_q[NUM_D-1:0];
        bus.dfi_wrdata_p1      <= wdata_q[2*NUM_D-1:NUM_D];
        bus.dfi_wrdata_mask_p0 <= wmask_q[MW-1:0];
        bus.dfi_wrdata_mask_p1 <= wmask_q[2*MW-1:MW];
      end else begin
        bus.dfi_wrdata_en_p1   <= 1'b0;
        bus.dfi_wrdata_p0      <= '0;
        bus.dfi_wrdata_p1      <= '0;
        bus.dfi_wrdata_mask_p0 <= '0;
        bus.dfi_wrdata_mask_p1 <= '0;
      end

      if (state == ST_WAIT_RD) begin
        if (rd_hit) bus.rsp_rdata <= {bus.dfi_rddata_w1, bus.dfi_rddata_w0};
        else if (rd_to) bus.rsp_rdata <= '0;
      end

      // Down-counter for fixed waits, up-counter for the read timeout.
      unique case (state)
        ST_ACT:                              cnt <= RCD_LD;
        ST_DATA:                             cnt <= we_q ? WR_LD : 4'd0;
        ST_PRE:                              cnt <= RP_LD;
        ST_WAIT_RCD, ST_WAIT_WR, ST_WAIT_RP: cnt <= cnt - 4'd1;
        ST_WAIT_RD:                          cnt <= cnt + 4'd1;
        default:                             cnt <= cnt;
      endcase
    end
  end

  dfi_phase_drv #(.NUM_AD(NUM_AD), .NUM_BA(NUM_BA)) u_p0 (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .load    (p0_load),
    .cmd     (p0_cmd),
    .addr    (p0_addr),
    .bank    (p0_bank),
    .cs_n    (bus.dfi_cs_n_p0),
    .ras_n   (bus.dfi_ras_n_p0),
    .cas_n   (bus.dfi_cas_n_p0),
    .we_n    (bus.dfi_we_n_p0),
    .address (bus.dfi_address_p0),
    .ba      (bus.dfi_bank_p0)
  );

  dfi_phase_drv #(.NUM_AD(NUM_AD), .NUM_BA(NUM_BA)) u_p1 (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .load    (p1_load),
    .cmd     (p1_cmd),
    .addr    (p1_addr),
    .bank    (p1_bank),
    .cs_n    (bus.dfi_cs_n_p1),
    .ras_n   (bus.dfi_ras_n_p1),
    .cas_n   (bus.dfi_cas_n_p1),
    .we_n    (bus.dfi_we_n_p1),
    .address (bus.dfi_address_p1),
    .ba      (bus.dfi_bank_p1)
  );

endmodule

// File: tb/tb_dfi_initiator.sv
// Bench for dfi_initiator: directed and random requests against a cycle-schedule model of the
// ACT/CMD/DATA/PRE sequence; define DFI_RD_TIMEOUT_EN to also cover the read timeout.
module tb_dfi_initiator;

  localparam int NUM_AD = 13, NUM_BA = 2, NUM_D = 64;
  localparam int T_RCD = 2, T_WR = 3, T_RP = 2, RD_TIMEOUT = 15;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100, PRE = 4'b0010;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dfi_initiator_if #(.NUM_AD(NUM_AD), .NUM_BA(NUM_BA), .NUM_D(NUM_D)) bus ();

  dfi_initiator #(
    .NUM_AD(NUM_AD), .NUM_BA(NUM_BA), .NUM_D(NUM_D),
    .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [3:0] c0, c1;
  assign c0 = {bus.dfi_cs_n_p0, bus.dfi_ras_n_p0, bus.dfi_cas_n_p0, bus.dfi_we_n_p0};
  assign c1 = {bus.dfi_cs_n_p1, bus.dfi_ras_n_p1, bus.dfi_cas_n_p1, bus.dfi_we_n_p1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Issue one request at cycle 0 and check every output each cycle until IDLE is settled.
  // Read data: both valids at DATA+lat; optional single-sided valid part_gap cycles earlier.
  task automatic run_req(input bit we, input logic [1:0] bank, input logic [12:0] row,
                         input logic [12:0] col, input logic [127:0] wdata, input logic [15:0] wmask,
                         input int lat, input int part_gap, input bit part_w1, input bit no_valid,
                         input logic [127:0] rdata);
    int cmd_c, data_c, pre_c, hit_c, part_c, last;
    logic [12:0] colx;
    logic [3:0] e0, e1;
    logic [12:0] a0, a1;
    logic [1:0] b0, b1;
    bit ewe, ere, erv;
    string sfx;
    colx = col;
    colx[10] = 1'b0;
    cmd_c  = 1 + T_RCD;
    data_c = cmd_c + 1;
    hit_c  = no_valid ? -100 : data_c + lat;
    part_c = (part_gap > 0) ? hit_c - part_gap : -100;
    if (we) pre_c = data_c + T_WR;
    else if (no_valid) pre_c = data_c + 1 + RD_TIMEOUT;
    else pre_c = hit_c + 1;
    last = pre_c + T_RP + 1;

    @(posedge sys_clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_bank  = bank;
    bus.req_row   = row;
    bus.req_col   = col;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    @(negedge sys_clk);
    chk("ready@0", bus.req_ready, 1'b1);
    chk("cmd_p0@0", c0, NOP);

    for (int t = 1; t <= last; t++) begin
      @(posedge sys_clk); #1;
      bus.req_valid = 1'b0;
      bus.req_we    = $urandom_range(0, 1);
      bus.req_row   = 13'($urandom());
      bus.req_col   = 13'($urandom());
      bus.req_wdata = rnd128();
      bus.dfi_rddata_valid_w0 = (t == hit_c) || (t == part_c && !part_w1);
      bus.dfi_rddata_valid_w1 = (t == hit_c) || (t == part_c && part_w1);
      {bus.dfi_rddata_w1, bus.dfi_rddata_w0} = (t == hit_c) ? rdata : rnd128();
      @(negedge sys_clk);

      e0 = NOP; a0 = '0; b0 = '0; e1 = NOP; a1 = '0; b1 = '0;
      ewe = 1'b0; ere = 1'b0; erv = 1'b0;
      if (t == 1) begin e0 = ACT; a0 = row; b0 = bank; end
      if (t == cmd_c) begin
        if (we) begin e1 = WR; a1 = colx; b1 = bank; end
        else    begin e0 = RD; a0 = colx; b0 = bank; end
      end
      if (t == data_c) begin ewe = we; ere = !we; end
      if (t == pre_c) begin e0 = PRE; a0 = 13'h0400; erv = 1'b1; end

      sfx = $sformatf("@%0d", t);
      chk({"cmd_p0", sfx}, c0, e0);
      chk({"addr_p0", sfx}, bus.dfi_address_p0, a0);
      chk({"bank_p0", sfx}, bus.dfi_bank_p0, b0);
      chk({"cmd_p1", sfx}, c1, e1);
      chk({"addr_p1", sfx}, bus.dfi_address_p1, a1);
      chk({"bank_p1", sfx}, bus.dfi_bank_p1, b1);
      chk({"wrdata_en", sfx}, bus.dfi_wrdata_en_p1, ewe);
      chk({"rddata_en", sfx}, bus.dfi_rddata_en_p0, ere);
      chk({"rsp_valid", sfx}, bus.rsp_valid, erv);
      if (ewe) begin
        chk({"wrdata", sfx}, {bus.dfi_wrdata_p1, bus.dfi_wrdata_p0}, wdata);
        chk({"wrmask", sfx}, {bus.dfi_wrdata_mask_p1, bus.dfi_wrdata_mask_p0}, wmask);
      end
      if (erv) begin
        chk({"rsp_err", sfx}, bus.rsp_err, !we && no_valid);
        if (!we) chk({"rsp_rdata", sfx}, bus.rsp_rdata, no_valid ? 128'd0 : rdata);
      end
      if (t < pre_c + T_RP) chk({"ready_busy", sfx}, bus.req_ready, 1'b0);
      else if (t > pre_c + T_RP) chk({"ready_back", sfx}, bus.req_ready, 1'b1);
    end
    bus.dfi_rddata_valid_w0 = 1'b0;
    bus.dfi_rddata_valid_w1 = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_bank = '0; bus.req_row = '0;
    bus.req_col = '0; bus.req_wdata = '0; bus.req_wmask = '0;
    bus.dfi_rddata_w0 = '0; bus.dfi_rddata_w1 = '0;
    bus.dfi_rddata_valid_w0 = 1'b0; bus.dfi_rddata_valid_w1 = 1'b0;

    #22;
    chk("rst_cmd_p0", c0, NOP);
    chk("rst_cmd_p1", c1, NOP);
    chk("rst_addr", {bus.dfi_address_p1, bus.dfi_address_p0}, 26'd0);
    chk("rst_bank", {bus.dfi_bank_p1, bus.dfi_bank_p0}, 4'd0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b00);
    chk("rst_rdata", bus.rsp_rdata, 128'd0);
    chk("rst_en", {bus.dfi_wrdata_en_p1, bus.dfi_rddata_en_p0}, 2'b00);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run_req(1'b1, 2'd1, 13'h0dbe, 13'h0010, {64'h0123456789abcdef, 64'hcafebabeabadface},
            16'h3412, 0, 0, 1'b0, 1'b0, '0);
    run_req(1'b0, 2'd2, 13'h1234, 13'h0020, '0, '0, 3, 0, 1'b0, 1'b0,
            {64'habadfacecafebabe, 64'hdeadbeef12345678});
    run_req(1'b0, 2'd3, 13'h0777, 13'h0420, '0, '0, 5, 2, 1'b0, 1'b0, rnd128());
    run_req(1'b0, 2'd0, 13'h0001, 13'h0008, '0, '0, 4, 2, 1'b1, 1'b0, rnd128());

    // Reset pulse while waiting for tRCD: outputs drop to NOP at once, no WRITE follows.
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_bank = 2'd2;
    bus.req_row = 13'h0abc; bus.req_col = 13'h0044; bus.req_wdata = rnd128(); bus.req_wmask = 16'hffff;
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b0;
    @(negedge sys_clk);
    chk("rstmid_act", c0, ACT);
    @(posedge sys_clk); #2;
    chk("rstmid_busy", bus.req_ready, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    chk("rstmid_ready", bus.req_ready, 1'b1);
    chk("rstmid_cmd", {c1, c0}, {NOP, NOP});
    @(negedge sys_clk);
    chk("rstmid_no_wr", c1, NOP);
    chk("rstmid_addr", bus.dfi_address_p1, 13'd0);
    sys_rst_n = 1'b1;
    run_req(1'b0, 2'd1, 13'h0555, 13'h0100, '0, '0, 2, 0, 1'b0, 1'b0, rnd128());

    for (int i = 0; i < 12; i++) begin
      logic [12:0] col;
      int lat;
      col = 13'($urandom());
      if (i % 2 == 0) col[10] = 1'b1;
      lat = $urandom_range(1, 8);
      run_req(1'($urandom_range(0, 1)), 2'($urandom()), 13'($urandom()), col, rnd128(),
              16'($urandom()), lat, (lat >= 3 && $urandom_range(0, 1) == 1) ? $urandom_range(1, lat - 2) : 0,
              1'($urandom_range(0, 1)), 1'b0, rnd128());
    end

`ifdef DFI_RD_TIMEOUT_EN
    run_req(1'b0, 2'd3, 13'h0fff, 13'h0030, '0, '0, 0, 0, 1'b0, 1'b1, '0);
    run_req(1'b0, 2'd1, 13'h0101, 13'h0040, '0, '0, 6, 3, 1'b1, 1'b0, rnd128());
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
